// File: rtl/btn_conditioner_pkg.sv
// Shared definitions for the button input stage: debounce FSM encoding, default window, channel indices.
// No logic; latency and flow control are defined by the modules importing this package.
package btn_conditioner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'b00,
    ST_PRESS_WAIT   = 2'b01,
    ST_HELD         = 2'b10,
    ST_RELEASE_WAIT = 2'b11
  } btn_state_e;

  // 20 ms at a 50 MHz board clock
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1_000_000;

  localparam int unsigned BTN_R = 0;
  localparam int unsigned BTN_L = 1;

  function automatic int unsigned cnt_width(input int unsigned cycles);
    return $clog2(cycles);
  endfunction

endpackage

// File: rtl/btn_conditioner_debounce_ch.sv
// One button channel: 2-FF synchroniser, debounce FSM, registered level/press/release outputs.
// Accepts a change after DEBOUNCE_CYCLES+2 edges of stable input; no backpressure, pulses are one clock wide.
module btn_debounce_ch
  import btn_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             sync;
  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;

  assign sync = sync_q[1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q    <= 2'b00;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], btn_raw_i};
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // The counter is checked against its terminal value before incrementing, so it never wraps.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sync) begin
          state_d = ST_PRESS_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      ST_PRESS_WAIT: begin
        if (!sync) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_HELD;
          cnt_d   = '0;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_HELD: begin
        if (!sync) begin
          state_d = ST_RELEASE_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      ST_RELEASE_WAIT: begin
        if (sync) begin
          state_d = ST_HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/btn_conditioner.sv
// N_BTN independent debounced button channels feeding the game FSM press/release events.
// DEBOUNCE_CYCLES+2 edges from a stable input change to output; no backpressure.
module btn_conditioner
  import btn_conditioner_pkg::*;
#(
  parameter int unsigned N_BTN           = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk_i    (clk),
      .rst_ni   (reset),
      .btn_raw_i(btn_raw[g]),
      .level_o  (btn_level[g]),
      .press_o  (btn_press[g]),
      .release_o(btn_release[g])
    );
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Table-driven bench for btn_conditioner (N_BTN=2, DEBOUNCE_CYCLES=4) with a scoreboard queue
// and hand sequences for the asynchronous reset corner cases.
module tb_btn_conditioner;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] btn_raw = 2'b00;
  logic [1:0] btn_level, btn_press, btn_release;

  btn_conditioner #(
    .N_BTN(2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic [1:0] raw;
    logic [1:0] lvl;
    logic [1:0] prs;
    logic [1:0] rel;
  } vec_t;

  vec_t       vecs[$];
  logic [5:0] exp_q[$];
  int         n_chk = 0;
  int         n_pass = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic add(input int n, input logic rst_n, input logic [1:0] raw,
                     input logic [1:0] lvl, input logic [1:0] prs, input logic [1:0] rel);
    vec_t v;
    v.rst_n = rst_n; v.raw = raw; v.lvl = lvl; v.prs = prs; v.rel = rel;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  // Count edges until btn_press[0] rises; returns 99 if it never does within the budget.
  task automatic edges_to_press(output int n);
    n = 99;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (btn_press[0]) begin
        n = k;
        break;
      end
    end
  endtask

  initial begin
    logic [5:0] exp, got;
    int         n;

    // Reset held with both buttons down, then released with them still held.
    add(3, 1'b0, 2'b11, 2'b00, 2'b00, 2'b00);
    add(5, 1'b1, 2'b11, 2'b00, 2'b00, 2'b00);
    add(1, 1'b1, 2'b11, 2'b11, 2'b11, 2'b00);
    add(2, 1'b1, 2'b11, 2'b11, 2'b00, 2'b00);
    add(5, 1'b1, 2'b00, 2'b11, 2'b00, 2'b00);
    add(1, 1'b1, 2'b00, 2'b00, 2'b00, 2'b11);
    add(3, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00);
    // Clean press/release on channel 0.
    add(5, 1'b1, 2'b01, 2'b00, 2'b00, 2'b00);
    add(1, 1'b1, 2'b01, 2'b01, 2'b01, 2'b00);
    add(14, 1'b1, 2'b01, 2'b01, 2'b00, 2'b00);
    add(5, 1'b1, 2'b00, 2'b01, 2'b00, 2'b00);
    add(1, 1'b1, 2'b00, 2'b00, 2'b00, 2'b01);
    add(3, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00);
    // Bounce on channel 1 before a stable press.
    add(2, 1'b1, 2'b10, 2'b00, 2'b00, 2'b00);
    add(2, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00);
    add(2, 1'b1, 2'b10, 2'b00, 2'b00, 2'b00);
    add(2, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00);
    add(5, 1'b1, 2'b10, 2'b00, 2'b00, 2'b00);
    add(1, 1'b1, 2'b10, 2'b10, 2'b10, 2'b00);
    add(4, 1'b1, 2'b10, 2'b10, 2'b00, 2'b00);
    add(5, 1'b1, 2'b00, 2'b10, 2'b00, 2'b00);
    add(1, 1'b1, 2'b00, 2'b00, 2'b00, 2'b10);
    add(3, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00);
    // Short release glitch while channel 0 is held.
    add(5, 1'b1, 2'b01, 2'b00, 2'b00, 2'b00);
    add(1, 1'b1, 2'b01, 2'b01, 2'b01, 2'b00);
    add(4, 1'b1, 2'b01, 2'b01, 2'b00, 2'b00);
    add(2, 1'b1, 2'b00, 2'b01, 2'b00, 2'b00);
    add(10, 1'b1, 2'b01, 2'b01, 2'b00, 2'b00);
    add(5, 1'b1, 2'b00, 2'b01, 2'b00, 2'b00);
    add(1, 1'b1, 2'b00, 2'b00, 2'b00, 2'b01);
    add(3, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00);
    // Simultaneous press of both channels.
    add(5, 1'b1, 2'b11, 2'b00, 2'b00, 2'b00);
    add(1, 1'b1, 2'b11, 2'b11, 2'b11, 2'b00);
    add(3, 1'b1, 2'b11, 2'b11, 2'b00, 2'b00);
    add(5, 1'b1, 2'b00, 2'b11, 2'b00, 2'b00);
    add(1, 1'b1, 2'b00, 2'b00, 2'b00, 2'b11);
    add(3, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00);

    #1;
    check("reset_outputs", {26'd0, btn_level, btn_press, btn_release}, 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset   = vecs[i].rst_n;
      btn_raw = vecs[i].raw;
      exp_q.push_back({vecs[i].lvl, vecs[i].prs, vecs[i].rel});
      @(posedge clk); #1;
      got = {btn_level, btn_press, btn_release};
      exp = exp_q.pop_front();
      check($sformatf("vec[%0d] lvl/prs/rel", i), {26'd0, got}, {26'd0, exp});
    end

    // Reset asserted during the press pulse, then released with the button still held.
    @(negedge clk);
    btn_raw = 2'b01;
    edges_to_press(n);
    check("press_latency", n, 6);
    check("press_pulse", {30'd0, btn_press}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("rst_mid_press_outputs", {26'd0, btn_level, btn_press, btn_release}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("no_pulse_on_rst_release", {26'd0, btn_level, btn_press, btn_release}, 32'd0);
    edges_to_press(n);
    check("press_latency_after_rst", n, 5);
    check("level_after_rst_press", {30'd0, btn_level}, 32'd1);
    @(posedge clk); #1;
    check("press_falls_after_rst", {30'd0, btn_press}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
